// File: rtl/hub75_fb_mem_core.sv
// Framebuffer store: N_SPRAM 16-bit SPRAM banks ganged in width, round-robin grant among
// N_PORTS clients, and 1/2/3-deep frame buffering with swaps aligned to the display frame boundary.
module hub75_fb_mem_core #(
    parameter int N_PORTS = 2,
    parameter int N_SPRAM = 1,
    parameter int N_FB    = 2,
    parameter int ADDR_W  = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_PORTS-1:0]    req_i,
    output logic [N_PORTS-1:0]    gnt_o,
    input  logic [N_PORTS-1:0]    rel_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [16*N_SPRAM-1:0] wr_data_i,
    input  logic [4*N_SPRAM-1:0]  wr_mask_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    input  logic                  rd_en_i,
    output logic [16*N_SPRAM-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  frame_swap_i,
    input  logic                  frame_sync_i,
    output logic                  swap_ack_o,
    output logic                  err_o
);

    localparam int DATA_W = 16 * N_SPRAM;
    localparam int PTR_W  = $clog2(N_PORTS);
    localparam logic [1:0] WR_RST = (N_FB >= 2) ? 2'd1 : 2'd0;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    arb_state_t         state_q, state_d;
    logic [N_PORTS-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   pick;
    logic               found;

    logic [1:0]         wr_buf_q, wr_buf_d;
    logic [1:0]         rd_buf_q, rd_buf_d;
    logic [1:0]         rdy_q, rdy_d;
    logic               pending_q, pending_d;
    logic               fresh_q, fresh_d;
    logic               ack_q, ack_d;
    logic               swap_err;

    logic [DATA_W-1:0]  rd_data_q;
    logic               rd_valid_q;
    logic               err_q, err_d;
    logic [1:0]         buf_sel;
    logic [13:0]        phys_addr;
    logic [DATA_W-1:0]  mem_rd;

    // Arbiter: search starts at rr_ptr so every client gets a turn.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        pick    = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!found && req_i[(int'(ptr_q) + k) % N_PORTS]) begin
                found = 1'b1;
                pick  = PTR_W'((int'(ptr_q) + k) % N_PORTS);
            end
        end
        case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    ptr_d       = (pick == PTR_W'(N_PORTS - 1)) ? '0 : pick + 1'b1;
                    state_d     = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if ((rel_i & gnt_q) != '0) begin
                    gnt_d   = '0;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        wr_buf_d  = wr_buf_q;
        rd_buf_d  = rd_buf_q;
        rdy_d     = rdy_q;
        pending_d = pending_q;
        fresh_d   = fresh_q;
        ack_d     = 1'b0;
        swap_err  = 1'b0;
        if (N_FB == 1) begin
            wr_buf_d = 2'd0;
            rd_buf_d = 2'd0;
            ack_d    = frame_swap_i;
        end else if (N_FB == 2) begin
            swap_err = frame_swap_i && pending_q;
            if (frame_sync_i && (pending_q || frame_swap_i)) begin
                wr_buf_d  = rd_buf_q;
                rd_buf_d  = wr_buf_q;
                pending_d = 1'b0;
                ack_d     = 1'b1;
            end else if (frame_swap_i) begin
                pending_d = 1'b1;
            end
        end else begin
            // Swap is applied before sync so a same-cycle pair shows the just-finished frame.
            if (frame_swap_i) begin
                wr_buf_d = rdy_q;
                rdy_d    = wr_buf_q;
                fresh_d  = 1'b1;
                ack_d    = 1'b1;
            end
            if (frame_sync_i && fresh_d) begin
                rd_buf_d = rdy_d;
                rdy_d    = rd_buf_q;
                fresh_d  = 1'b0;
            end
        end
    end

    assign buf_sel   = wr_en_i ? wr_buf_q : rd_buf_q;
    assign phys_addr = {buf_sel, 12'(wr_en_i ? wr_addr_i : rd_addr_i)};

    for (genvar s = 0; s < N_SPRAM; s++) begin : g_spram
        logic [15:0] mem [0:16383];
        always_ff @(posedge clk_i) begin
            if (wr_en_i) begin
                for (int n = 0; n < 4; n++) begin
                    if (wr_mask_i[s*4+n]) begin
                        mem[phys_addr][n*4 +: 4] <= wr_data_i[s*16+n*4 +: 4];
                    end
                end
            end
        end
        assign mem_rd[s*16 +: 16] = mem[phys_addr];
    end

    assign err_d = err_q | (wr_en_i & rd_en_i) | (|(rel_i & ~gnt_q)) | swap_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            ptr_q      <= '0;
            wr_buf_q   <= WR_RST;
            rd_buf_q   <= 2'd0;
            rdy_q      <= 2'd2;
            pending_q  <= 1'b0;
            fresh_q    <= 1'b0;
            ack_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            wr_buf_q   <= wr_buf_d;
            rd_buf_q   <= rd_buf_d;
            rdy_q      <= rdy_d;
            pending_q  <= pending_d;
            fresh_q    <= fresh_d;
            ack_q      <= ack_d;
            rd_valid_q <= rd_en_i & ~wr_en_i;
            if (rd_en_i && !wr_en_i) begin
                rd_data_q <= mem_rd;
            end
            err_q      <= err_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign swap_ack_o = ack_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_hub75_fb_mem_core.sv
// Bench for hub75_fb_mem_core: a double- and a triple-buffered instance share one stimulus stream.
module tb_hub75_fb_mem_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req = '0, rel = '0;
    logic [11:0] wr_addr = '0, rd_addr = '0;
    logic [31:0] wr_data = '0;
    logic [7:0]  wr_mask = '0;
    logic        wr_en = 1'b0, rd_en = 1'b0, fs = 1'b0, fy = 1'b0;

    logic [2:0]  gnt2, gnt3;
    logic [31:0] rdd2, rdd3;
    logic        rdv2, rdv3, ack2, ack3, err2, err3;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hub75_fb_mem_core #(.N_PORTS(3), .N_SPRAM(2), .N_FB(2), .ADDR_W(12)) u_d2 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt2), .rel_i(rel),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_mask_i(wr_mask), .wr_en_i(wr_en),
        .rd_addr_i(rd_addr), .rd_en_i(rd_en), .rd_data_o(rdd2), .rd_valid_o(rdv2),
        .frame_swap_i(fs), .frame_sync_i(fy), .swap_ack_o(ack2), .err_o(err2));

    hub75_fb_mem_core #(.N_PORTS(3), .N_SPRAM(2), .N_FB(3), .ADDR_W(12)) u_d3 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt3), .rel_i(rel),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_mask_i(wr_mask), .wr_en_i(wr_en),
        .rd_addr_i(rd_addr), .rd_en_i(rd_en), .rd_data_o(rdd3), .rd_valid_o(rdv3),
        .frame_swap_i(fs), .frame_sync_i(fy), .swap_ack_o(ack3), .err_o(err3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req = '0; rel = '0; wr_en = 0; rd_en = 0; fs = 0; fy = 0;
        wr_mask = '0; wr_data = '0; wr_addr = '0; rd_addr = '0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic write_word(input logic [11:0] a, input logic [31:0] d, input logic [7:0] m);
        wr_en = 1; wr_addr = a; wr_data = d; wr_mask = m;
        tick();
        wr_en = 0; wr_mask = '0;
    endtask

    task automatic read_both(input string name, input logic [11:0] a, input logic [31:0] e2,
                             input logic [31:0] e3);
        rd_en = 1; rd_addr = a;
        tick();
        rd_en = 0;
        chk({name, "_valid2"}, 32'(rdv2), 32'd1);
        chk({name, "_data2"}, rdd2, e2);
        chk({name, "_valid3"}, 32'(rdv3), 32'd1);
        chk({name, "_data3"}, rdd3, e3);
    endtask

    typedef struct {
        logic [2:0] req;
        logic [2:0] rel;
        logic [2:0] gnt;
    } arb_vec_t;

    arb_vec_t tbl[13];

    // Behavioural reference state for the randomized phase
    int          m_owner, m_ptr;
    int          m_wr[2], m_rd[2], m_rdy[2];
    bit          m_pend, m_fresh;
    bit          m_err[2], m_ack[2], m_val[2], m_known[2];
    logic [31:0] m_data[2];
    logic [31:0] mm[int];
    logic [7:0]  mk[int];

    initial begin
        int hi_cnt;
        logic [2:0] pre_gnt, exp_gnt;
        logic [31:0] act_d;
        bit act_v, act_a, act_e;
        int key, t_wr, t_rdy;

        tbl[0]  = '{3'b111, 3'b000, 3'b001};
        tbl[1]  = '{3'b111, 3'b000, 3'b001};
        tbl[2]  = '{3'b111, 3'b000, 3'b001};
        tbl[3]  = '{3'b111, 3'b001, 3'b000};
        tbl[4]  = '{3'b111, 3'b000, 3'b010};
        tbl[5]  = '{3'b111, 3'b000, 3'b010};
        tbl[6]  = '{3'b111, 3'b000, 3'b010};
        tbl[7]  = '{3'b111, 3'b010, 3'b000};
        tbl[8]  = '{3'b111, 3'b000, 3'b100};
        tbl[9]  = '{3'b111, 3'b000, 3'b100};
        tbl[10] = '{3'b111, 3'b000, 3'b100};
        tbl[11] = '{3'b111, 3'b100, 3'b000};
        tbl[12] = '{3'b111, 3'b000, 3'b001};

        do_reset();
        chk("rst_gnt2", 32'(gnt2), 0);
        chk("rst_gnt3", 32'(gnt3), 0);
        chk("rst_rdv2", 32'(rdv2), 0);
        chk("rst_rdd2", rdd2, 0);
        chk("rst_ack2", 32'(ack2), 0);
        chk("rst_err2", 32'(err2), 0);
        chk("rst_err3", 32'(err3), 0);

        // Round-robin: each owner holds 4 cycles, releases, next grant after one dead cycle
        for (int i = 0; i < 13; i++) begin
            req = tbl[i].req;
            rel = tbl[i].rel;
            tick();
            chk($sformatf("rr%0d_gnt2", i), 32'(gnt2), 32'(tbl[i].gnt));
            chk($sformatf("rr%0d_gnt3", i), 32'(gnt3), 32'(tbl[i].gnt));
        end
        quiet();
        chk("rr_no_err", 32'(err2), 0);

        // Masked write, then a combined swap+sync makes the write buffer visible on both
        do_reset();
        write_word(12'd5, 32'hDEADBEEF, 8'hFF);
        write_word(12'd5, 32'h0000_1234, 8'h0F);
        fs = 1; fy = 1;
        tick();
        fs = 0; fy = 0;
        chk("mask_ack2", 32'(ack2), 1);
        chk("mask_ack3", 32'(ack3), 1);
        read_both("mask", 12'd5, 32'hDEAD1234, 32'hDEAD1234);
        tick();
        chk("mask_valid_pulse", 32'(rdv2), 0);

        // Double buffer: ack deferred until frame_sync
        do_reset();
        write_word(12'd7, 32'hA5A5_0001, 8'hFF);
        fs = 1;
        tick();
        fs = 0;
        chk("defer_ack3_now", 32'(ack3), 1);
        hi_cnt = int'(ack2);
        for (int i = 0; i < 39; i++) begin
            tick();
            hi_cnt += int'(ack2) + int'(ack3);
        end
        chk("defer_no_early_ack", hi_cnt, 0);
        fy = 1;
        tick();
        fy = 0;
        chk("defer_ack2", 32'(ack2), 1);
        chk("defer_ack3_quiet", 32'(ack3), 0);
        tick();
        chk("defer_ack2_1cyc", 32'(ack2), 0);
        read_both("defer", 12'd7, 32'hA5A5_0001, 32'hA5A5_0001);

        // Triple buffer: two swaps without sync, then sync shows the newest frame
        do_reset();
        write_word(12'd9, 32'h1111_1111, 8'hFF);
        fs = 1;
        tick();
        fs = 0;
        chk("tri_ack_a", 32'(ack3), 1);
        repeat (8) tick();
        write_word(12'd9, 32'h2222_2222, 8'hFF);
        fs = 1;
        tick();
        fs = 0;
        chk("tri_ack_b", 32'(ack3), 1);
        chk("dbl_drop_err2", 32'(err2), 1);
        chk("tri_no_err3", 32'(err3), 0);
        fy = 1;
        tick();
        fy = 0;
        chk("tri_rdbuf", 32'(u_d3.rd_buf_q), 2);
        rd_en = 1; rd_addr = 12'd9;
        tick();
        rd_en = 0;
        chk("tri_read_a", rdd3, 32'h2222_2222);
        fy = 1;
        tick();
        fy = 0;
        rd_en = 1;
        tick();
        rd_en = 0;
        chk("tri_read_b", rdd3, 32'h2222_2222);

        // Write and read together: write wins, no rd_valid, sticky err
        do_reset();
        wr_en = 1; rd_en = 1; wr_addr = 12'd3; rd_addr = 12'd3;
        wr_data = 32'hCAFE_F00D; wr_mask = 8'hFF;
        tick();
        quiet();
        chk("coll_rdv2", 32'(rdv2), 0);
        chk("coll_err2", 32'(err2), 1);
        fs = 1; fy = 1;
        tick();
        fs = 0; fy = 0;
        read_both("coll", 12'd3, 32'hCAFE_F00D, 32'hCAFE_F00D);
        repeat (5) tick();
        chk("coll_err_sticky", 32'(err3), 1);
        do_reset();
        chk("err_cleared", 32'(err2), 0);
        rel = 3'b100;
        tick();
        rel = '0;
        chk("rel_nonowner_err", 32'(err2), 1);

        // Asynchronous reset while port 1 owns the grant
        do_reset();
        req = 3'b010;
        tick();
        chk("rg_gnt1", 32'(gnt2), 32'b010);
        req = 3'b011;
        #2 rst = 1'b1;
        #1;
        chk("rg_async_clear", 32'(gnt2), 0);
        tick();
        rst = 1'b0;
        chk("rg_wrbuf", 32'(u_d2.wr_buf_q), 1);
        chk("rg_rdbuf", 32'(u_d2.rd_buf_q), 0);
        tick();
        chk("rg_port0_first", 32'(gnt2), 32'b001);
        quiet();

        // Randomized traffic against the reference model
        do_reset();
        m_owner = -1; m_ptr = 0;
        m_pend = 0; m_fresh = 0;
        for (int d = 0; d < 2; d++) begin
            m_wr[d] = 1; m_rd[d] = 0; m_rdy[d] = 2; m_err[d] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            req = 3'($urandom_range(0, 7));
            rel = '0;
            if (m_owner >= 0 && $urandom_range(0, 3) == 0) rel[m_owner] = 1'b1;
            if ($urandom_range(0, 60) == 0) rel[$urandom_range(0, 2)] = 1'b1;
            wr_en = ($urandom_range(0, 2) == 0);
            rd_en = !wr_en && ($urandom_range(0, 1) == 1);
            wr_addr = 12'($urandom_range(0, 7));
            rd_addr = 12'($urandom_range(0, 7));
            wr_data = $urandom;
            wr_mask = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            fs = ($urandom_range(0, 15) == 0);
            fy = ($urandom_range(0, 11) == 0);

            pre_gnt = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
            for (int d = 0; d < 2; d++) begin
                if ((rel & ~pre_gnt) != 0) m_err[d] = 1;
                m_val[d] = rd_en;
                if (rd_en) begin
                    key = d * 65536 + m_rd[d] * 4096 + int'(rd_addr);
                    m_known[d] = mk.exists(key) && mk[key] == 8'hFF;
                    m_data[d] = m_known[d] ? mm[key] : 32'h0;
                end else begin
                    m_known[d] = 0;
                end
                if (wr_en) begin
                    key = d * 65536 + m_wr[d] * 4096 + int'(wr_addr);
                    if (!mk.exists(key)) begin
                        mm[key] = '0;
                        mk[key] = '0;
                    end
                    for (int n = 0; n < 8; n++) begin
                        if (wr_mask[n]) begin
                            mm[key][n*4 +: 4] = wr_data[n*4 +: 4];
                            mk[key][n] = 1'b1;
                        end
                    end
                end
            end
            m_ack[0] = 0;
            if (fs && m_pend) m_err[0] = 1;
            if (fy && (m_pend || fs)) begin
                t_wr = m_wr[0]; m_wr[0] = m_rd[0]; m_rd[0] = t_wr;
                m_pend = 0; m_ack[0] = 1;
            end else if (fs) begin
                m_pend = 1;
            end
            m_ack[1] = fs;
            if (fs) begin
                t_wr = m_wr[1]; m_wr[1] = m_rdy[1]; m_rdy[1] = t_wr; m_fresh = 1;
            end
            if (fy && m_fresh) begin
                t_rdy = m_rdy[1]; m_rdy[1] = m_rd[1]; m_rd[1] = t_rdy; m_fresh = 0;
            end
            if (m_owner < 0) begin
                for (int k = 0; k < 3; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % 3]) m_owner = (m_ptr + k) % 3;
                end
                if (m_owner >= 0) m_ptr = (m_owner + 1) % 3;
            end else if (rel[m_owner]) begin
                m_owner = -1;
            end
            exp_gnt = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;

            tick();
            chk($sformatf("rnd%0d_gnt2", cyc), 32'(gnt2), 32'(exp_gnt));
            chk($sformatf("rnd%0d_gnt3", cyc), 32'(gnt3), 32'(exp_gnt));
            for (int d = 0; d < 2; d++) begin
                act_v = (d == 0) ? rdv2 : rdv3;
                act_d = (d == 0) ? rdd2 : rdd3;
                act_a = (d == 0) ? ack2 : ack3;
                act_e = (d == 0) ? err2 : err3;
                chk($sformatf("rnd%0d_rdv_d%0d", cyc, d), 32'(act_v), 32'(m_val[d]));
                if (m_val[d] && m_known[d])
                    chk($sformatf("rnd%0d_rdd_d%0d", cyc, d), act_d, m_data[d]);
                chk($sformatf("rnd%0d_ack_d%0d", cyc, d), 32'(act_a), 32'(m_ack[d]));
                chk($sformatf("rnd%0d_err_d%0d", cyc, d), 32'(act_e), 32'(m_err[d]));
            end
        end
        quiet();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
